input_conditioner_3ch: RTL

- Three-channel input conditioner for raw, asynchronous external signals (switches, pins).
- Each channel is synchronized into the clk domain, then debounced.
- Clean, glitch-free levels out_1..out_3 feed the downstream combinational AND/OR gate stage directly on its in_1..in_3.
- One shared sample tick sets the debounce time base for all channels.

---
 rtl/input_cond_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 140 ++++++++++++++
 rtl/input_conditioner_3ch.sv | 85 ++++++++
 3 files changed

// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_cond_pkg
// Purpose  : Shared state encoding and default sizing for the three-channel
//            input conditioner and its debounce channels.
// Revision : 1.0 - initial release
// ============================================================================
package input_cond_pkg;

    // Per-channel debounce state: STABLE while the counter is idle,
    // SETTLING while a candidate new level is being qualified.
    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    localparam int c_default_cnt_w         = 4;
    localparam int c_default_stable_cycles = 8;

endpackage : input_cond_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One input channel: SYNC_STAGES-deep synchronizer followed by a
//            tick-gated debounce counter/state machine. Optional edge-pulse
//            outputs are built when INPUT_COND_EDGE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = c_default_stable_cycles,
    parameter int   CNT_W         = c_default_cnt_w,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic out,
`ifdef INPUT_COND_EDGE_EN
    output logic rise,
    output logic fall,
`endif
    output logic busy
);

    // Reject configurations where the synchronizer is too short or the
    // counter could not reach STABLE_CYCLES-1 without wrapping.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("debounce_channel: SYNC_STAGES must be at least 2");
        end
        if ((STABLE_CYCLES < 1) || (STABLE_CYCLES > (2 ** CNT_W) - 1)) begin : g_bad_stable_cycles
            $error("debounce_channel: STABLE_CYCLES must be in 1..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one_cnt  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_out;
    logic                   w_out_nxt;
    logic                   r_busy;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchronizer chain; free-running, independent of tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce state, counter, output level and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_out   <= RESET_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= (w_cnt_nxt != '0);
        end
    end

    // Next-state logic; everything holds on edges without tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        if (tick) begin
            case (r_state)
                ST_STABLE: begin
                    w_cnt_nxt = '0;
                    if (w_s != r_out) begin
                        if (STABLE_CYCLES == 1) begin
                            w_out_nxt = w_s;
                        end else begin
                            w_cnt_nxt   = c_one_cnt;
                            w_state_nxt = ST_SETTLING;
                        end
                    end
                end
                ST_SETTLING: begin
                    if (w_s == r_out) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == c_last_cnt) begin
                        w_out_nxt   = w_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one_cnt;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;

`ifdef INPUT_COND_EDGE_EN
    logic r_rise;
    logic r_fall;

    // One-clock pulses marking the edge on which the debounced level flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_out_nxt & ~r_out;
            r_fall <= ~w_out_nxt & r_out;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`endif

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner_3ch.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner_3ch
// Purpose  : Three independent synchronize-and-debounce channels sharing one
//            sample tick. Optional macro INPUT_COND_EDGE_EN adds registered
//            rise_n / fall_n edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner_3ch
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = c_default_stable_cycles,
    parameter int   CNT_W         = c_default_cnt_w,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_1,
    input  logic raw_2,
    input  logic raw_3,
    output logic out_1,
    output logic out_2,
    output logic out_3,
`ifdef INPUT_COND_EDGE_EN
    output logic rise_1,
    output logic rise_2,
    output logic rise_3,
    output logic fall_1,
    output logic fall_2,
    output logic fall_3,
`endif
    output logic busy
);

    logic [2:0] w_raw;
    logic [2:0] w_out;
    logic [2:0] w_busy;
`ifdef INPUT_COND_EDGE_EN
    logic [2:0] w_rise;
    logic [2:0] w_fall;
`endif

    assign w_raw = {raw_3, raw_2, raw_1};

    // One fully independent debounce channel per input.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_CYCLES (STABLE_CYCLES),
                .CNT_W         (CNT_W),
                .RESET_LEVEL   (RESET_LEVEL)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick),
                .raw   (w_raw[gi]),
                .out   (w_out[gi]),
`ifdef INPUT_COND_EDGE_EN
                .rise  (w_rise[gi]),
                .fall  (w_fall[gi]),
`endif
                .busy  (w_busy[gi])
            );
        end
    endgenerate

    assign out_1 = w_out[0];
    assign out_2 = w_out[1];
    assign out_3 = w_out[2];
    assign busy  = |w_busy;

`ifdef INPUT_COND_EDGE_EN
    assign rise_1 = w_rise[0];
    assign rise_2 = w_rise[1];
    assign rise_3 = w_rise[2];
    assign fall_1 = w_fall[0];
    assign fall_2 = w_fall[1];
    assign fall_3 = w_fall[2];
`endif

endmodule : input_conditioner_3ch
`default_nettype wire
